// File: rtl/ring_monitor_if.sv
// Ring monitor sample/status bundle.
// Macro RING_MONITOR_IRQ_EN adds the err_irq status line.
interface ring_monitor_if;
  logic [7:0] ring_in;
  logic       sample_en;
  logic       clear_err;
  logic [2:0] index_out;
  logic       onehot_ok;
  logic       locked;
  logic [7:0] rev_count;
  logic [7:0] err_count;
  logic       err_flag;
`ifdef RING_MONITOR_IRQ_EN
  logic       err_irq;
`endif

  modport master (
    output ring_in,
    output sample_en,
    output clear_err,
    input  index_out,
    input  onehot_ok,
    input  locked,
    input  rev_count,
    input  err_count,
`ifdef RING_MONITOR_IRQ_EN
    input  err_irq,
`endif
    input  err_flag
  );

  modport slave (
    input  ring_in,
    input  sample_en,
    input  clear_err,
    output index_out,
    output onehot_ok,
    output locked,
    output rev_count,
    output err_count,
`ifdef RING_MONITOR_IRQ_EN
    output err_irq,
`endif
    output err_flag
  );
endinterface

// File: rtl/ring_monitor.sv
// One-hot ring counter monitor: lock tracking, revolutions, faults.
// Macro RING_MONITOR_IRQ_EN adds the err_irq pulse output.
module ring_monitor #(
  parameter int LOCK_CNT = 3
) (
  input logic          clk,
  input logic          reset,
  ring_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    LOCKED,
    FAULT
  } state_t;

  localparam logic [3:0] LOCK_TGT = LOCK_CNT[3:0];

  state_t     state;
  state_t     state_nxt;
  logic [7:0] prev;
  logic [3:0] match;
  logic [3:0] match_nxt;
  logic [3:0] match_inc;
  logic       valid;
  logic       step_ok;
  logic [2:0] enc;
  logic       fault_entry;
  logic       rev_hit;

  assign valid   = (bus.ring_in != 8'h00) &&
                   ((bus.ring_in & (bus.ring_in - 8'd1)) == 8'h00);
  assign step_ok = valid &&
                   (bus.ring_in == {prev[6:0], prev[7]});
  assign match_inc = match + 4'd1;

  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ring_in[i]) enc = i[2:0];
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match;
    unique case (state)
      SEARCH: begin
        if (bus.sample_en && valid) begin
          state_nxt = LOCKING;
          match_nxt = 4'd0;
        end
      end
      LOCKING: begin
        if (bus.sample_en) begin
          if (step_ok) begin
            if (match_inc == LOCK_TGT) begin
              state_nxt = LOCKED;
              match_nxt = 4'd0;
            end else begin
              match_nxt = match_inc;
            end
          end else if (valid) begin
            match_nxt = 4'd0;
          end else begin
            state_nxt = SEARCH;
            match_nxt = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (bus.sample_en && !step_ok) begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        // Fault is a one-cycle marker; the exit ignores sample_en
        state_nxt = SEARCH;
        match_nxt = 4'd0;
      end
      default: begin
        state_nxt = SEARCH;
        match_nxt = 4'd0;
      end
    endcase
  end

  assign fault_entry = (state_nxt == FAULT) &&
                       (state != FAULT);
  assign rev_hit = bus.sample_en &&
                   (state == LOCKED) &&
                   step_ok &&
                   (bus.ring_in == 8'h01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      match <= 4'd0;
      prev  <= 8'h00;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
      if (bus.sample_en) prev <= bus.ring_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.index_out <= 3'd0;
      bus.onehot_ok <= 1'b0;
      bus.locked    <= 1'b0;
      bus.rev_count <= 8'h00;
    end else begin
      bus.locked <= (state_nxt == LOCKED);
      if (bus.sample_en) begin
        bus.onehot_ok <= valid;
        if (valid) bus.index_out <= enc;
      end
      if (rev_hit) bus.rev_count <= bus.rev_count + 8'd1;
    end
  end

  // A fault in the same cycle as clear_err restarts the count at one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.err_count <= 8'h00;
      bus.err_flag  <= 1'b0;
    end else if (fault_entry) begin
      bus.err_flag <= 1'b1;
      if (bus.clear_err) begin
        bus.err_count <= 8'h01;
      end else if (bus.err_count != 8'hFF) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
    end else if (bus.clear_err) begin
      bus.err_count <= 8'h00;
      bus.err_flag  <= 1'b0;
    end
  end

`ifdef RING_MONITOR_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.err_irq <= 1'b0;
    else       bus.err_irq <= (state_nxt == FAULT);
  end
`endif

endmodule
